mul_product_datapath: RTL
=========================

Name: mul_product_datapath

Overview:
- Shift-add datapath for the unsigned sequential multiplier.
- Sits directly downstream of the multiplier control FSM and consumes its w_ctrl_Multiplicand, w_ctrl_Product and adding_ctrl strobes.
- Returns the product LSB to the FSM as its add decision.
- Holds the multiplicand register, a WIDTH-bit adder with carry-out, the 2*WIDTH product/multiplier register and a step counter with a done flag.

Parameters:
- WIDTH, 32: operand width in bits; the product is 2*WIDTH bits.
- CNT_W, 6: step counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- w_ctrl_Multiplicand  input  1  load strobe: capture operands and start a new multiply.
- w_ctrl_Product  input  1  step enable: perform one add/shift iteration.
- adding_ctrl  input  1  qualifies the step: add the multiplicand before shifting.
- multiplicand_in  input  WIDTH  multiplicand operand.
- multiplier_in  input  WIDTH  multiplier operand.
- lsb  output  1  product[0], fed back to the control FSM.
- product  output  2*WIDTH  product register contents.
- step_cnt  output  CNT_W  number of steps executed since the last load.
- done  output  1  high when step_cnt == WIDTH.

Behaviour:
- Reset (async, rst=1): mcand=0, product=0, step_cnt=0. Outputs are therefore lsb=0 and done=0. Reset wins over every strobe.
- Reset mid-multiply: all state clears immediately. The first cycle after rst deasserts needs a new load; steps without a load act on zero operands (product stays 0).
- Load (w_ctrl_Multiplicand=1 at a clk edge): mcand <= multiplicand_in; product <= {WIDTH'b0, multiplier_in}; step_cnt <= 0. The load has priority over a simultaneous step; the step is dropped.
- Step (w_ctrl_Product=1, no load, done=0):
  - {c, s} = product[2W-1:W] + mcand (WIDTH+1-bit sum).
  - adding_ctrl=1: product <= {c, s, product[W-1:1]}.
  - adding_ctrl=0: product <= {1'b0, product[2W-1:1]}.
  - In both cases step_cnt <= step_cnt + 1.
- adding_ctrl with w_ctrl_Product=0: no effect.
- Steps while done=1 are ignored; product and step_cnt hold. This guards against controller over-run and counter wrap.
- Latency: an operand load followed by WIDTH step cycles gives the final product. It is visible in the cycle after the WIDTH-th step edge, and done asserts in that same cycle.
- Outputs:
  - lsb and done are combinational from registers, with no input-to-output comb path.
  - product is a direct register output.
- Carry: the adder carry-out is never lost. It becomes product[2W-1] after the shift, so the full 2W-bit result is exact for all unsigned operands.
- No state machine is needed beyond the implicit IDLE/RUN/DONE encoded by step_cnt:
  - step_cnt == 0 after load: RUN at start.
  - 0 < step_cnt < WIDTH: RUN.
  - step_cnt == WIDTH: DONE.
- A new load is accepted in any state, including RUN. It restarts the multiply cleanly.

Test Plan:
- Reset then load 3×5, then 32 steps with adding_ctrl driven from lsb -> product=64'h0000_0000_0000_000F; done=1 after the 32nd step; step_cnt=32.
- Load 0xFFFF_FFFF×0xFFFF_FFFF, then 32 steps with adding_ctrl driven from lsb -> product=64'hFFFF_FFFE_0000_0001. This checks carry retention into the MSB.
- Load 0×0x1234_5678 and 0x1234_5678×0, each with 32 steps -> product=0; lsb follows the shifted multiplier bits; done=1.
- Load, 10 steps, assert rst for 1 cycle mid-clock -> product, step_cnt and lsb clear immediately (no clk edge needed). Reload 7×9 with 32 steps -> product=63.
- w_ctrl_Multiplicand and w_ctrl_Product both high with operands 2×6 -> load wins: product={32'b0, 32'd6} and step_cnt=0. Then 32 steps -> product=12.
- After done with 3×5, apply 5 extra steps with adding_ctrl=1 -> product stays 15 and step_cnt stays 32. adding_ctrl=1 with w_ctrl_Product=0 during RUN -> no change.

Source files
------------

// File: rtl/mul_product_datapath.sv
// Shift-add datapath for the unsigned sequential multiplier: multiplicand register,
// WIDTH-bit adder with carry, 2*WIDTH product/multiplier register and step counter.
module mul_product_datapath #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_ctrl_Multiplicand,
    input  logic                 w_ctrl_Product,
    input  logic                 adding_ctrl,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    output logic                 lsb,
    output logic [2*WIDTH-1:0]   product,
    output logic [CNT_W-1:0]     step_cnt,
    output logic                 done
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   sum;

    // Carry-out is kept as the top bit of sum so it lands in product[2W-1] after the shift.
    assign sum  = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    assign lsb  = product[0];
    assign done = (step_cnt == CNT_W'(WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            product  <= '0;
            step_cnt <= '0;
        end else if (w_ctrl_Multiplicand) begin
            mcand    <= multiplicand_in;
            product  <= {{WIDTH{1'b0}}, multiplier_in};
            step_cnt <= '0;
        end else if (w_ctrl_Product && !done) begin
            // Steps past done are dropped so an over-running controller cannot wrap the count.
            if (adding_ctrl) begin
                product <= {sum, product[WIDTH-1:1]};
            end else begin
                product <= {1'b0, product[2*WIDTH-1:1]};
            end
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

endmodule
